// File: rtl/mmio_sig_host.sv
// Compliance-test MMIO host: signature FIFO, halt decode and drain sequencing.
// Sits on the core data write port beside the backing memory.
module mmio_sig_host #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] SIG_ADDR   = 32'hF000_0004,
  parameter logic [31:0] HALT_ADDR  = 32'hF000_0000,
  parameter logic [31:0] HALT_MAGIC = 32'hCAFE_CAFE,
  localparam int         AW         = $clog2(FIFO_DEPTH),
  localparam int         CW         = AW + 1
) (
  input  logic          sysclk,
  input  logic          rst_in,
  input  logic [31:0]   dmem_wr_addr,
  input  logic [31:0]   dmem_wr_data,
  input  logic          dmem_wr_en,
  output logic          mem_wr_en,
  output logic [31:0]   sig_data,
  output logic          sig_valid,
  input  logic          sig_ready,
  output logic [CW-1:0] sig_count,
  output logic          overflow,
  output logic          halt_seen,
  output logic          done
);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt_nxt;

  logic sig_hit;
  logic halt_hit;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign sig_hit  = dmem_wr_en
                  & (dmem_wr_addr == SIG_ADDR);
  assign halt_hit = dmem_wr_en
                  & (dmem_wr_addr == HALT_ADDR)
                  & (dmem_wr_data == HALT_MAGIC);

  assign mem_wr_en = dmem_wr_en & ~halt_hit;

  assign sig_valid = (sig_count != '0);
  assign sig_data  = mem[rd_ptr];

  assign full = (sig_count == CW'(FIFO_DEPTH));
  assign pop  = sig_valid & sig_ready;

  // A full FIFO still takes a push when the head leaves this cycle.
  assign push = sig_hit & (state == S_RUN) & (~full | pop);
  assign drop = sig_hit & (state == S_RUN) & full & ~pop;

  assign cnt_nxt = sig_count
                 + {{AW{1'b0}}, push}
                 - {{AW{1'b0}}, pop};

  always_ff @(posedge sysclk) begin
    if (push && !rst_in)
      mem[wr_ptr] <= dmem_wr_data;
  end

  always_ff @(posedge sysclk) begin
    if (rst_in) begin
      state     <= S_RUN;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      sig_count <= '0;
      overflow  <= 1'b0;
      halt_seen <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      sig_count <= cnt_nxt;
      if (drop)
        overflow <= 1'b1;
      unique case (state)
        S_RUN: begin
          if (halt_hit) begin
            state     <= S_DRAIN;
            halt_seen <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (cnt_nxt == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule
